pe_feed_packetizer: RTL and testbench
=====================================

// Module: pe_feed_packetizer
// PURPOSE
//  Transmit side of the PE packet interface. Reads filter words from a weight buffer and
//  ifmap spike rows from an input buffer, and formats them into 34-bit NoC packets for the
//  PE depacketizers: kernel-type packets first, then input-type packets.
//  Sits between the memory node and the NoC router, one layer pass per start pulse.
// PARAMETERS
//  NUM_PE      3        number of PEs fed; PE p has address {p[1:0],2'b10} (0010,0110,1010)
//  NUM_ROWS    5        ifmap rows sent per pass
//  SRC_ADDR    4'b0011  source address stamped into pkt_data[33:30]
//  ROW_W       5        ifmap row width (spike bits)
//  FIL_W       24       filter word width (3 x 8-bit weights; w0 in [7:0])
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      pulse: begin a pass (sampled only in IDLE)
//  busy        out  1      high from the cycle after an accepted start until done
//  done        out  1      one-cycle pulse after the last packet handshake
//  wmem_addr   out  $clog2(NUM_PE)    weight buffer read address
//  wmem_rdata  in   FIL_W             weight data, valid 1 cycle after wmem_addr
//  imem_addr   out  $clog2(NUM_ROWS)  ifmap buffer read address
//  imem_rdata  in   ROW_W             row data, valid 1 cycle after imem_addr
//  pkt_valid   out  1      packet valid
//  pkt_ready   in   1      downstream ready; transfer when valid && ready on a rising edge
//  pkt_data    out  34     {src[33:30], dst[29:26], type[25:24], payload[23:0]}
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, pkt_valid = 0; pkt_data, wmem_addr, imem_addr, counters = 0.
//   Reset is asynchronous and may assert mid-pass: the pass is abandoned and no partial
//   handshake completes. After deassertion the block waits for a new start.
//  FSM:
//   IDLE   -> RD_W on start; clear idx.
//   RD_W   drive wmem_addr=idx -> SEND_W.
//   SEND_W assert pkt_valid with {SRC_ADDR, pe_addr(idx), 2'b01, wmem_rdata}.
//          On handshake: if idx==NUM_PE-1, clear idx and go to RD_I; else idx++ and go to RD_W.
//   RD_I   drive imem_addr=idx -> SEND_I.
//   SEND_I assert pkt_valid with {SRC_ADDR, pe_addr(min(idx,NUM_PE-1)), 2'b00, 19'b0, row}.
//          On handshake: if idx==NUM_ROWS-1, go to DONE; else idx++ and go to RD_I.
//   DONE   done=1 for one cycle -> IDLE.
//  Output register: the read data is captured into pkt_data on entry to the SEND_* state.
//   pkt_data and pkt_valid hold stable while pkt_valid && !pkt_ready.
//   pkt_valid never drops without a handshake.
//  Latency: start edge -> pkt_valid high 2 cycles later. Peak rate is 1 packet per 2 cycles.
//   A pass is NUM_PE+NUM_ROWS packets; with pkt_ready tied high, done occurs
//   2*(NUM_PE+NUM_ROWS)+1 cycles after start.
//  start while busy or in DONE is ignored, with no queuing.
//   pkt_ready while !pkt_valid has no effect.
//  Packet assembly: payload bits above the field width are zero. Destination encoding is
//   pe_addr(p) = {p[1:0],2'b10}. Rows with idx >= NUM_PE all go to the last PE, which
//   forwards them down the chain.
//  Index counter width is $clog2(max(NUM_PE,NUM_ROWS)+1); it never wraps within a pass.
// STRUCTURE
//  Package snn_pkt_pkg holds:
//   - widths PKT_W=34, ADDR_W=4, TYPE_W=2, PAYLOAD_W=24
//   - typedef pkt_type_e {INPUT=2'b00, KERNEL=2'b01, MEM=2'b10}
//   - typedef pkt_t (packed struct src/dst/type/payload)
//   - function pe_addr(idx), and constants PE1/2/3_ADDR, ADDER1/2/3_ADDR
//  Single module; the FSM state typedef stays local. No sub-module is warranted.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> busy, done, pkt_valid = 0 immediately (asynchronous).
//  2 Full pass, pkt_ready=1, wmem={24'h030201,24'h060504,24'h090807},
//    imem={5'h01,5'h02,5'h04,5'h08,5'h10}. Expect 8 packets in order:
//     KERNEL to dst 0010/0110/1010 carrying 030201/060504/090807;
//     INPUT to dst 0010,0110,1010,1010,1010 carrying rows 01..10, payload[23:5]=0.
//    done occurs 17 cycles after start.
//  3 Backpressure: pkt_ready=0 for 5 cycles during the 2nd packet -> pkt_data is unchanged
//    and pkt_valid stays 1; the sequence resumes with no duplicate or lost packet.
//  4 Random pkt_ready (50%) over 20 passes -> the scoreboard matches test 2 exactly.
//  5 start pulsed during a pass -> ignored; exactly 8 packets and one done pulse.
//  6 rst_n low while in SEND_I (row 2) -> pkt_valid drops. A new start then produces the
//    full 8-packet sequence from the filter phase.

Source files
------------

// File: rtl/snn_pkt_pkg.sv
// Shared packet format for the SNN PE network: field widths, packet types,
// the packed packet layout and the node address map.
package snn_pkt_pkg;

  localparam int PKT_W     = 34;
  localparam int ADDR_W    = 4;
  localparam int TYPE_W    = 2;
  localparam int PAYLOAD_W = 24;

  typedef enum logic [TYPE_W-1:0] {
    INPUT  = 2'b00,
    KERNEL = 2'b01,
    MEM    = 2'b10
  } pkt_type_e;

  typedef struct packed {
    logic [ADDR_W-1:0]    src;
    logic [ADDR_W-1:0]    dst;
    pkt_type_e            ptype;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  localparam logic [ADDR_W-1:0] PE1_ADDR    = 4'b0010;
  localparam logic [ADDR_W-1:0] PE2_ADDR    = 4'b0110;
  localparam logic [ADDR_W-1:0] PE3_ADDR    = 4'b1010;
  localparam logic [ADDR_W-1:0] ADDER1_ADDR = 4'b0001;
  localparam logic [ADDR_W-1:0] ADDER2_ADDR = 4'b0101;
  localparam logic [ADDR_W-1:0] ADDER3_ADDR = 4'b1001;

  // PEs sit on addresses ending in 2'b10, indexed by the upper two bits.
  function automatic logic [ADDR_W-1:0] pe_addr(input logic [1:0] p);
    return {p, 2'b10};
  endfunction

endpackage

// File: rtl/pe_feed_packetizer.sv
// Memory-node transmit side: streams one filter packet per PE, then the ifmap
// rows as input packets, through a valid/ready port into the NoC router.
module pe_feed_packetizer
  import snn_pkt_pkg::*;
#(
  parameter int                NUM_PE   = 3,
  parameter int                NUM_ROWS = 5,
  parameter logic [ADDR_W-1:0] SRC_ADDR = 4'b0011,
  parameter int                ROW_W    = 5,
  parameter int                FIL_W    = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_PE)-1:0]   wmem_addr,
  input  logic [FIL_W-1:0]            wmem_rdata,
  output logic [$clog2(NUM_ROWS)-1:0] imem_addr,
  input  logic [ROW_W-1:0]            imem_rdata,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic [PKT_W-1:0]            pkt_data
);

  localparam int WA_W  = $clog2(NUM_PE);
  localparam int IA_W  = $clog2(NUM_ROWS);
  localparam int IDX_W = $clog2(((NUM_PE > NUM_ROWS) ? NUM_PE : NUM_ROWS) + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_W, S_SEND_W, S_RD_I, S_SEND_I, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WA_W-1:0]   wmem_addr_q, wmem_addr_d;
  logic [IA_W-1:0]   imem_addr_q, imem_addr_d;
  pkt_t              pkt_q, pkt_d;
  pkt_t              kern_pkt, in_pkt;
  logic [1:0]        row_dst;
  logic              last_w, last_i;

  assign last_w = (idx_q == IDX_W'(NUM_PE - 1));
  assign last_i = (idx_q == IDX_W'(NUM_ROWS - 1));

  // Rows beyond the PE count all land on the last PE, which relays them onward.
  assign row_dst = (idx_q > IDX_W'(NUM_PE - 1)) ? 2'(NUM_PE - 1) : idx_q[1:0];

  always_comb begin
    kern_pkt                     = '0;
    kern_pkt.src                 = SRC_ADDR;
    kern_pkt.dst                 = pe_addr(idx_q[1:0]);
    kern_pkt.ptype               = KERNEL;
    kern_pkt.payload[FIL_W-1:0]  = wmem_rdata;
    in_pkt                       = '0;
    in_pkt.src                   = SRC_ADDR;
    in_pkt.dst                   = pe_addr(row_dst);
    in_pkt.ptype                 = INPUT;
    in_pkt.payload[ROW_W-1:0]    = imem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wmem_addr_q <= '0;
      imem_addr_q <= '0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wmem_addr_q <= wmem_addr_d;
      imem_addr_q <= imem_addr_d;
      pkt_q       <= pkt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_W;
          idx_d   = '0;
        end
      end
      S_RD_W: begin
        state_d = S_SEND_W;
        pkt_d   = kern_pkt;
      end
      S_SEND_W: begin
        if (pkt_ready) begin
          if (last_w) begin
            idx_d   = '0;
            state_d = S_RD_I;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_W;
          end
        end
      end
      S_RD_I: begin
        state_d = S_SEND_I;
        pkt_d   = in_pkt;
      end
      S_SEND_I: begin
        if (pkt_ready) begin
          if (last_i) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_I;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Buffer addresses are registered on entry to the read state so the
    // read data is settled by the time it is captured into the packet.
    wmem_addr_d = (state_d == S_RD_W) ? WA_W'(idx_d) : wmem_addr_q;
    imem_addr_d = (state_d == S_RD_I) ? IA_W'(idx_d) : imem_addr_q;
  end

  always_comb begin
    busy      = (state_q == S_RD_W) || (state_q == S_SEND_W) ||
                (state_q == S_RD_I) || (state_q == S_SEND_I);
    pkt_valid = (state_q == S_SEND_W) || (state_q == S_SEND_I);
    done      = (state_q == S_DONE);
  end

  assign wmem_addr = wmem_addr_q;
  assign imem_addr = imem_addr_q;
  assign pkt_data  = pkt_q;

endmodule

// File: tb/tb_pe_feed_packetizer.sv
// Directed bench for pe_feed_packetizer: cycle table for a full pass, then
// backpressure, random-ready, ignored-start and mid-pass reset sequences.
module tb_pe_feed_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  wmem_addr;
  logic [23:0] wmem_rdata;
  logic [2:0]  imem_addr;
  logic [4:0]  imem_rdata;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [33:0] pkt_data;

  logic [23:0] wmem [3];
  logic [4:0]  imem [5];

  pe_feed_packetizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .wmem_addr  (wmem_addr),
    .wmem_rdata (wmem_rdata),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data)
  );

  always #5 clk = ~clk;

  assign wmem_rdata = (wmem_addr < 2'd3) ? wmem[wmem_addr] : 24'h0;
  assign imem_rdata = (imem_addr < 3'd5) ? imem[imem_addr] : 5'h0;

  int total = 0;
  int bad   = 0;

  logic [33:0] exp_pkt [8];
  logic [33:0] got [$];

  typedef struct {
    logic        start;
    logic        exp_busy;
    logic        exp_valid;
    logic        exp_done;
    logic [33:0] exp_data;
  } vec_t;
  vec_t tv [18];

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n && pkt_valid && pkt_ready) got.push_back(pkt_data);
  end

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_scoreboard(input string nm);
    logic [33:0] a;
    chk({nm, "_count"}, 34'(got.size()), 34'd8);
    for (int i = 0; i < 8; i++) begin
      a = (i < got.size()) ? got[i] : 34'bx;
      chk($sformatf("%s_pkt%0d", nm, i), a, exp_pkt[i]);
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: stall 2nd packet 5 cycles;
  // 3: ready high with extra start pulses mid-pass and in DONE.
  task automatic run_pass(input int mode, output int done_cyc, output int ndone);
    bit          seen;
    int          extra;
    int          stall;
    logic [33:0] hold;
    seen = 0; extra = 3; stall = 0; ndone = 0; done_cyc = 0; hold = '0;
    got.delete();
    start = 1'b1;
    pkt_ready = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (done) begin
        ndone++;
        if (!seen) begin
          seen = 1;
          done_cyc = cyc;
        end
      end
      if (seen) begin
        if (extra == 0) break;
        extra--;
      end
      start = (mode == 3) && (cyc == 3 || cyc == 9 || done);
      if (mode == 1) begin
        pkt_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2 && stall < 5 && (stall > 0 || (pkt_valid && got.size() == 1))) begin
        pkt_ready = 1'b0;
        if (stall == 0) begin
          hold = pkt_data;
        end else begin
          chk("stall_data", pkt_data, hold);
          chk("stall_valid", 34'(pkt_valid), 34'd1);
        end
        stall++;
      end else begin
        pkt_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!seen) chk("pass_timeout", 34'd0, 34'd1);
    start = 1'b0;
    pkt_ready = 1'b1;
  endtask

  int dcyc, nd;

  initial begin
    wmem[0] = 24'h030201; wmem[1] = 24'h060504; wmem[2] = 24'h090807;
    imem[0] = 5'h01; imem[1] = 5'h02; imem[2] = 5'h04; imem[3] = 5'h08; imem[4] = 5'h10;

    exp_pkt[0] = {4'b0011, 4'b0010, 2'b01, 24'h030201};
    exp_pkt[1] = {4'b0011, 4'b0110, 2'b01, 24'h060504};
    exp_pkt[2] = {4'b0011, 4'b1010, 2'b01, 24'h090807};
    exp_pkt[3] = {4'b0011, 4'b0010, 2'b00, 24'h000001};
    exp_pkt[4] = {4'b0011, 4'b0110, 2'b00, 24'h000002};
    exp_pkt[5] = {4'b0011, 4'b1010, 2'b00, 24'h000004};
    exp_pkt[6] = {4'b0011, 4'b1010, 2'b00, 24'h000008};
    exp_pkt[7] = {4'b0011, 4'b1010, 2'b00, 24'h000010};

    // Full pass with ready high: odd cycles present packet k, even cycles re-read.
    tv[0] = '{start: 1'b1, exp_busy: 1'b1, exp_valid: 1'b0, exp_done: 1'b0, exp_data: '0};
    for (int k = 0; k < 8; k++) begin
      tv[2*k+1] = '{start: 1'b0, exp_busy: 1'b1, exp_valid: 1'b1, exp_done: 1'b0,
                    exp_data: exp_pkt[k]};
      if (k < 7)
        tv[2*k+2] = '{start: 1'b0, exp_busy: 1'b1, exp_valid: 1'b0, exp_done: 1'b0,
                      exp_data: '0};
    end
    tv[16] = '{start: 1'b0, exp_busy: 1'b0, exp_valid: 1'b0, exp_done: 1'b1, exp_data: '0};
    tv[17] = '{start: 1'b0, exp_busy: 1'b0, exp_valid: 1'b0, exp_done: 1'b0, exp_data: '0};

    // Reset state
    rst_n = 1'b0; start = 1'b0; pkt_ready = 1'b0;
    #3;
    chk("rst_busy", 34'(busy), 34'd0);
    chk("rst_valid", 34'(pkt_valid), 34'd0);
    chk("rst_done", 34'(done), 34'd0);
    chk("rst_data", pkt_data, 34'd0);
    chk("rst_waddr", 34'(wmem_addr), 34'd0);
    chk("rst_iaddr", 34'(imem_addr), 34'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cycle-by-cycle table
    got.delete();
    for (int i = 0; i < 18; i++) begin
      start = tv[i].start;
      pkt_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("tv%0d_busy", i), 34'(busy), 34'(tv[i].exp_busy));
      chk($sformatf("tv%0d_valid", i), 34'(pkt_valid), 34'(tv[i].exp_valid));
      chk($sformatf("tv%0d_done", i), 34'(done), 34'(tv[i].exp_done));
      if (tv[i].exp_valid) chk($sformatf("tv%0d_data", i), pkt_data, tv[i].exp_data);
    end
    start = 1'b0;
    check_scoreboard("table");

    run_pass(0, dcyc, nd);
    check_scoreboard("pass0");
    chk("pass0_done_lat", 34'(dcyc), 34'd17);
    chk("pass0_ndone", 34'(nd), 34'd1);

    // Backpressure on the second packet
    run_pass(2, dcyc, nd);
    check_scoreboard("stall");
    chk("stall_ndone", 34'(nd), 34'd1);
    chk("stall_done_lat", 34'(dcyc), 34'd22);

    // Random ready over many passes
    for (int p = 0; p < 20; p++) begin
      run_pass(1, dcyc, nd);
      check_scoreboard($sformatf("rnd%0d", p));
      chk($sformatf("rnd%0d_ndone", p), 34'(nd), 34'd1);
      chk($sformatf("rnd%0d_idle", p), 34'({busy, pkt_valid}), 34'd0);
    end

    // Start pulses during the pass and during DONE are ignored
    run_pass(3, dcyc, nd);
    check_scoreboard("restart");
    chk("restart_ndone", 34'(nd), 34'd1);
    chk("restart_done_lat", 34'(dcyc), 34'd17);
    chk("restart_idle", 34'({busy, pkt_valid}), 34'd0);

    // Asynchronous reset while row 2 is on the bus
    got.delete();
    start = 1'b1; pkt_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && !(pkt_valid && got.size() == 5); c++) begin
      @(posedge clk); #1;
    end
    pkt_ready = 1'b0;
    chk("row2_data", pkt_data, exp_pkt[5]);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 34'(pkt_valid), 34'd0);
    chk("midrst_busy", 34'(busy), 34'd0);
    chk("midrst_done", 34'(done), 34'd0);
    chk("midrst_data", pkt_data, 34'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_count", 34'(got.size()), 34'd5);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_wait", 34'({busy, pkt_valid, done}), 34'd0);
    run_pass(0, dcyc, nd);
    check_scoreboard("after_rst");
    chk("after_rst_done_lat", 34'(dcyc), 34'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
